// File: rtl/i2s_tx_if.sv
// Sample handshake between the effect chain (master) and the I2S transmitter (slave).
// The slave accepts a sample on any clk edge where sample_valid and sample_ready are both high.
interface i2s_tx_if;
   logic [31:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;

   modport master (output sample_in, output sample_valid, input sample_ready);
   modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk into BCLK/LRCLK and serialises a mono sample into both slots.
// One holding register decouples upstream; the last sample is replayed on underrun.
module i2s_tx #(
   parameter int CLK_DIV   = 4,
   parameter int SLOT_BITS = 32,
   parameter int DATA_BITS = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   i2s_tx_if.slave     s_if,
   input  logic        i_mute,
   output logic        o_bclk,
   output logic        o_lrclk,
   output logic        o_sdata,
   output logic        o_frame_start,
   output logic        o_underrun,
   output logic [15:0] o_underrun_cnt
);
   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam int EXT_W      = 1 << CNT_W;
   localparam int DIV_W      = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
   localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_BITS);

   logic [DIV_W-1:0]     r_div_cnt;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic                 r_bclk;
   logic                 r_lrclk;
   logic                 r_sdata;
   logic                 r_hold_full;
   logic                 r_ready;
   logic [DATA_BITS-1:0] r_hold;
   logic [DATA_BITS-1:0] r_frame;
   logic [DATA_BITS-1:0] r_last;
   logic                 r_frame_start;
   logic                 r_underrun;
   logic [15:0]          r_underrun_cnt;

   logic                 w_div_wrap;
   logic                 w_fall;
   logic                 w_load;
   logic                 w_xfer;
   logic [CNT_W-1:0]     w_next_bit;
   logic                 w_next_right;
   logic [CNT_W-1:0]     w_slot_pos;
   logic                 w_data_slot;
   logic [CNT_W-1:0]     w_bit_idx;
   logic [EXT_W-1:0]     w_frame_ext;
   logic [DATA_BITS-1:0] w_src;
   logic                 w_src_hold;
   logic                 w_src_none;
   logic                 w_hold_full_nxt;
   logic                 w_unused;

   assign w_div_wrap = (r_div_cnt == DIV_LAST);
   assign w_fall     = w_div_wrap & r_bclk;
   assign w_load     = w_fall & (r_bit_cnt == BIT_LAST);
   assign w_xfer     = s_if.sample_valid & r_ready;

   // Serial outputs are computed from the bit position being entered on this fall.
   assign w_next_bit   = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
   assign w_next_right = (w_next_bit >= SLOT_LEN);
   assign w_slot_pos   = w_next_right ? (w_next_bit - SLOT_LEN) : w_next_bit;
   assign w_data_slot  = (w_slot_pos != '0) && (w_slot_pos <= DATA_LEN);
   assign w_bit_idx    = DATA_LEN - w_slot_pos;
   assign w_frame_ext  = EXT_W'(r_frame);

   assign w_unused = ^s_if.sample_in[31:DATA_BITS];

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_src      = r_last;
      w_src_hold = 1'b0;
      w_src_none = 1'b0;
      if (r_hold_full) begin
         w_src      = r_hold;
         w_src_hold = 1'b1;
      end else if (w_xfer) begin
         w_src = s_if.sample_in[DATA_BITS-1:0];
      end else begin
         w_src_none = 1'b1;
      end
   end

   always_comb begin
      w_hold_full_nxt = r_hold_full;
      if (w_load) begin
         if (w_src_hold) w_hold_full_nxt = 1'b0;
      end else if (w_xfer) begin
         w_hold_full_nxt = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
         r_bit_cnt <= BIT_LAST;
         r_lrclk   <= 1'b1;
         r_sdata   <= 1'b0;
      end else begin
         if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
         if (w_fall) begin
            r_bit_cnt <= w_next_bit;
            r_lrclk   <= w_next_right;
            r_sdata   <= w_data_slot & w_frame_ext[w_bit_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_full <= 1'b0;
         r_ready     <= 1'b1;
         r_hold      <= '0;
         r_frame     <= '0;
         r_last      <= '0;
      end else begin
         r_hold_full <= w_hold_full_nxt;
         r_ready     <= ~w_hold_full_nxt;
         if (!w_load && w_xfer) r_hold <= s_if.sample_in[DATA_BITS-1:0];
         if (w_load) begin
            // Mute blanks the wire only; the source is still consumed and remembered.
            r_frame <= i_mute ? '0 : w_src;
            r_last  <= w_src;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_start  <= 1'b0;
         r_underrun     <= 1'b0;
         r_underrun_cnt <= '0;
      end else begin
         r_frame_start <= w_load;
         r_underrun    <= w_load & w_src_none;
         if (w_load && w_src_none && (r_underrun_cnt != 16'hFFFF))
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
   end

   assign s_if.sample_ready = r_ready;
   assign o_bclk            = r_bclk;
   assign o_lrclk           = r_lrclk;
   assign o_sdata           = r_sdata;
   assign o_frame_start     = r_frame_start;
   assign o_underrun        = r_underrun;
   assign o_underrun_cnt    = r_underrun_cnt;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a per-clk reference model derived from clk counts since reset,
// a table of frame vectors decoded off the wire, and hand sequences for handshake and reset corners.
module tb_i2s_tx;
   localparam int CLK_DIV    = 4;
   localparam int SLOT_BITS  = 32;
   localparam int DATA_BITS  = 24;
   localparam int BIT_CLKS   = 2 * CLK_DIV;
   localparam int FRAME_CLKS = 2 * SLOT_BITS * BIT_CLKS;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        mute  = 1'b0;
   logic        bclk, lrclk, sdata, frame_start, underrun;
   logic [15:0] ucnt;

   i2s_tx_if sif ();

   i2s_tx #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS), .DATA_BITS(DATA_BITS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_if           (sif),
      .i_mute         (mute),
      .o_bclk         (bclk),
      .o_lrclk        (lrclk),
      .o_sdata        (sdata),
      .o_frame_start  (frame_start),
      .o_underrun     (underrun),
      .o_underrun_cnt (ucnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time is measured in clk edges since reset release.
   int unsigned m_n;
   bit          m_pend;
   logic [23:0] m_hold, m_last, m_frame;
   logic [15:0] m_ucnt;
   bit          m_fs, m_ur;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_pend = 0; m_hold = '0; m_last = '0; m_frame = '0;
         m_ucnt = '0; m_fs = 0; m_ur = 0;
      end else begin
         bit          xfer;
         bit          load;
         logic [23:0] src;
         xfer = sif.sample_valid && !m_pend;
         m_n++;
         load = (m_n % BIT_CLKS == 0) && (((m_n / BIT_CLKS) - 1) % (2 * SLOT_BITS) == 0);
         m_fs = load;
         m_ur = 0;
         if (load) begin
            if (m_pend) begin
               src = m_hold;
               m_pend = 0;
            end else if (xfer) begin
               src = sif.sample_in[23:0];
            end else begin
               src = m_last;
               m_ur = 1;
               if (m_ucnt != 16'hFFFF) m_ucnt++;
            end
            m_frame = mute ? 24'h0 : src;
            m_last  = src;
         end else if (xfer) begin
            m_pend = 1;
            m_hold = sif.sample_in[23:0];
         end
      end
   end

   function automatic logic [21:0] expected_outputs();
      int unsigned k, pos, s;
      logic e_bclk, e_lr, e_sd;
      e_bclk = ((m_n / CLK_DIV) % 2) == 1;
      k      = m_n / BIT_CLKS;
      pos    = (k == 0) ? (2 * SLOT_BITS - 1) : ((k - 1) % (2 * SLOT_BITS));
      e_lr   = pos >= SLOT_BITS;
      s      = pos % SLOT_BITS;
      e_sd   = (s >= 1 && s <= DATA_BITS) ? m_frame[DATA_BITS - s] : 1'b0;
      return {e_bclk, e_lr, e_sd, ~m_pend, m_fs, m_ur, m_ucnt};
   endfunction

   bit chk_en = 0;
   always @(negedge clk)
      if (chk_en)
         check("cycle", {bclk, lrclk, sdata, sif.sample_ready, frame_start, underrun, ucnt},
               expected_outputs());

   task automatic do_reset();
      sif.sample_valid = 1'b0;
      mute = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("reset values", {bclk, lrclk, sdata, sif.sample_ready, frame_start, underrun, ucnt},
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Call at a negedge; returns at the negedge after the accepting posedge.
   task automatic push(input logic [31:0] data);
      bit done;
      done = 0;
      sif.sample_in    = data;
      sif.sample_valid = 1'b1;
      for (int i = 0; i < FRAME_CLKS + 16 && !done; i++) begin
         if (sif.sample_ready) done = 1;
         @(negedge clk);
      end
      sif.sample_valid = 1'b0;
      check("push accepted", done, 1'b1);
   endtask

   task automatic wait_fs(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < FRAME_CLKS + 16 && !ok; i++) begin
         @(negedge clk);
         if (frame_start) ok = 1;
      end
      check({name, " frame_start seen"}, ok, 1'b1);
   endtask

   // Call at the negedge where frame_start is high; samples each bit while BCLK is high.
   task automatic collect(input string name, input logic [23:0] exp_word);
      logic [63:0] bits;
      logic [23:0] left, right;
      logic [15:0] pad;
      bit          shape_ok;
      shape_ok = 1;
      repeat (CLK_DIV) @(negedge clk);
      for (int j = 0; j < 2 * SLOT_BITS; j++) begin
         if (j > 0) repeat (BIT_CLKS) @(negedge clk);
         bits[j] = sdata;
         if (bclk !== 1'b1 || lrclk !== (j >= SLOT_BITS)) shape_ok = 0;
      end
      for (int i = 0; i < 24; i++) begin
         left[23 - i]  = bits[1 + i];
         right[23 - i] = bits[33 + i];
      end
      pad = {bits[0], bits[31:25], bits[32], bits[63:57]};
      check({name, " left"}, left, exp_word);
      check({name, " right"}, right, exp_word);
      check({name, " pad zero"}, pad, 16'h0);
      check({name, " bclk/lrclk shape"}, shape_ok, 1'b1);
   endtask

   typedef struct {
      logic [31:0] sample;
      bit          push;
      bit          mute;
      logic [23:0] exp_word;
      bit          exp_ur;
      logic [15:0] exp_ucnt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      bit ok;
      sif.sample_in = '0;
      sif.sample_valid = 1'b0;
      vecs[0] = '{32'h00A5C3F1, 1, 0, 24'hA5C3F1, 0, 16'd0};
      vecs[1] = '{32'hFF000001, 1, 0, 24'h000001, 0, 16'd0};
      vecs[2] = '{32'h00FFFFFF, 1, 0, 24'hFFFFFF, 0, 16'd0};
      vecs[3] = '{32'h007FFFFF, 1, 1, 24'h000000, 0, 16'd0};
      vecs[4] = '{32'h00000000, 0, 0, 24'h7FFFFF, 1, 16'd1};
      vecs[5] = '{32'h00123456, 1, 0, 24'h123456, 0, 16'd1};
      vecs[6] = '{32'h00000000, 0, 0, 24'h123456, 1, 16'd2};
      vecs[7] = '{32'h00800000, 1, 0, 24'h800000, 0, 16'd2};

      repeat (2) @(negedge clk);
      chk_en = 1;

      // Reset release with no samples: divider timing and first (underrun) load.
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check($sformatf("release bclk c%0d", c), bclk, (c >= 4 && c < 8));
         check($sformatf("release lrclk c%0d", c), lrclk, (c < 8));
         check($sformatf("release frame_start c%0d", c), frame_start, (c == 8));
      end
      check("first load underrun", underrun, 1'b1);
      check("first load ucnt", ucnt, 16'd1);

      // Back-to-back samples: second waits for the holding register to drain.
      push(32'h00000001);
      check("ready drops when holding full", sif.sample_ready, 1'b0);
      fork
         push(32'h00FFFFFF);
         begin
            wait_fs("b2b first", ok);
            if (ok) collect("b2b first", 24'h000001);
         end
      join
      wait_fs("b2b second", ok);
      if (ok) collect("b2b second", 24'hFFFFFF);

      // Sample offered exactly on the load clk with holding empty goes straight to the frame.
      repeat (3) @(negedge clk);
      fork
         push(32'h00C0FFEE);
         wait_fs("bypass", ok);
      join
      check("bypass underrun", underrun, 1'b0);
      check("bypass keeps ready", sif.sample_ready, 1'b1);
      if (ok) collect("bypass", 24'hC0FFEE);

      // Reset mid-frame with holding full: holding discarded, first frame replays 0.
      wait_fs("pre reset", ok);
      push(32'h00ABCDEF);
      repeat (79) @(negedge clk);
      do_reset();
      wait_fs("after reset", ok);
      check("after reset underrun", underrun, 1'b1);
      check("after reset ucnt", ucnt, 16'd1);
      if (ok) collect("after reset", 24'h000000);

      // Table of frames from a clean reset.
      do_reset();
      for (int e = 0; e < 8; e++) begin
         mute = vecs[e].mute;
         if (vecs[e].push) push(vecs[e].sample);
         wait_fs($sformatf("vec%0d", e), ok);
         mute = 1'b0;
         check($sformatf("vec%0d underrun", e), underrun, vecs[e].exp_ur);
         check($sformatf("vec%0d ucnt", e), ucnt, vecs[e].exp_ucnt);
         if (ok) collect($sformatf("vec%0d", e), vecs[e].exp_word);
      end

      // Randomised traffic checked cycle by cycle against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (!(sif.sample_valid && !sif.sample_ready)) begin
            sif.sample_valid = ($urandom_range(0, 149) == 0);
            sif.sample_in    = $urandom();
         end
         mute = ($urandom_range(0, 9) == 0);
         @(negedge clk);
      end
      sif.sample_valid = 1'b0;
      mute = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
